// File: rtl/div_sqrt_issue_ctrl_pkg.sv
// Shared types and constants for the recoded-float div/sqrt issue controller.
// Holds the FSM state encoding, rounding-mode codes and exception-flag bit positions.
package fpu_divsqrt_pkg;

  // Recoded format carries one extra exponent bit over IEEE.
  function automatic int rec_w(input int exp_w, input int sig_w);
    return exp_w + sig_w + 1;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  localparam logic [7:0] LAT_MAX = 8'hFF;

endpackage

// File: rtl/div_sqrt_issue_ctrl_if.sv
// Handshake bundles for the issue controller: FPU request port, div/sqrt unit port, response port.
// The controller takes the slave side of the request bundle and the master side of the other two.
interface ds_req_if #(
  parameter int REC_W = 65,
  parameter int TAG_W = 5
);
  logic             req_valid;
  logic             req_ready;
  logic             req_sqrt;
  logic [REC_W-1:0] req_a;
  logic [REC_W-1:0] req_b;
  logic [2:0]       req_rm;
  logic [TAG_W-1:0] req_tag;

  modport master (output req_valid, req_sqrt, req_a, req_b, req_rm, req_tag, input req_ready);
  modport slave  (input req_valid, req_sqrt, req_a, req_b, req_rm, req_tag, output req_ready);
endinterface

interface ds_unit_if #(
  parameter int REC_W = 65
);
  logic             unit_in_ready;
  logic             unit_in_valid;
  logic             unit_sqrt_op;
  logic [REC_W-1:0] unit_a;
  logic [REC_W-1:0] unit_b;
  logic [2:0]       unit_rm;
  logic             unit_out_valid_div;
  logic             unit_out_valid_sqrt;
  logic [REC_W-1:0] unit_out;
  logic [4:0]       unit_exc_flags;

  modport master (output unit_in_valid, unit_sqrt_op, unit_a, unit_b, unit_rm,
                  input unit_in_ready, unit_out_valid_div, unit_out_valid_sqrt,
                  unit_out, unit_exc_flags);
  modport slave  (input unit_in_valid, unit_sqrt_op, unit_a, unit_b, unit_rm,
                  output unit_in_ready, unit_out_valid_div, unit_out_valid_sqrt,
                  unit_out, unit_exc_flags);
endinterface

interface ds_resp_if #(
  parameter int REC_W = 65,
  parameter int TAG_W = 5
);
  logic             resp_valid;
  logic             resp_ready;
  logic             resp_sqrt;
  logic [REC_W-1:0] resp_data;
  logic [4:0]       resp_flags;
  logic [TAG_W-1:0] resp_tag;
  logic [7:0]       resp_latency;

  modport master (output resp_valid, resp_sqrt, resp_data, resp_flags, resp_tag, resp_latency,
                  input resp_ready);
  modport slave  (input resp_valid, resp_sqrt, resp_data, resp_flags, resp_tag, resp_latency,
                  output resp_ready);
endinterface

// File: rtl/div_sqrt_issue_ctrl.sv
// Single-outstanding issue controller for the div/sqrt unit: accept, issue, await pulse, hold response.
// Flush kills the op at any stage; an in-flight result is drained and discarded.
module div_sqrt_issue_ctrl
  import fpu_divsqrt_pkg::*;
#(
  parameter int EXP_W = 11,
  parameter int SIG_W = 53,
  parameter int REC_W = rec_w(EXP_W, SIG_W),
  parameter int TAG_W = 5
) (
  input  logic       clock,
  input  logic       reset,
  ds_req_if.slave    req,
  ds_unit_if.master  unit,
  ds_resp_if.master  resp,
  input  logic       flush,
  output logic       busy,
  output logic       protocol_err
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_sqrt;
  logic [REC_W-1:0] r_a;
  logic [REC_W-1:0] r_b;
  logic [2:0]       r_rm;
  logic [TAG_W-1:0] r_tag;
  logic [7:0]       r_lat;
  logic [REC_W-1:0] r_resp_data;
  logic [4:0]       r_resp_flags;
  logic [7:0]       r_resp_lat;
  logic             r_perr;

  logic       w_accept;
  logic       w_issue_hs;
  logic       w_capture;
  logic       w_match;
  logic       w_other;
  logic       w_any;
  logic       w_perr_set;
  logic [7:0] w_lat_inc;

  // The pulse that belongs to the op in flight is selected by the latched op type.
  assign w_match    = r_sqrt ? unit.unit_out_valid_sqrt : unit.unit_out_valid_div;
  assign w_other    = r_sqrt ? unit.unit_out_valid_div  : unit.unit_out_valid_sqrt;
  assign w_any      = unit.unit_out_valid_div | unit.unit_out_valid_sqrt;
  assign w_lat_inc  = (r_lat == LAT_MAX) ? r_lat : r_lat + 8'd1;

  assign req.req_ready       = (r_state == ST_IDLE) & ~reset;
  assign unit.unit_in_valid  = (r_state == ST_ISSUE) & ~flush;
  assign unit.unit_sqrt_op   = r_sqrt;
  assign unit.unit_a         = r_a;
  assign unit.unit_b         = r_b;
  assign unit.unit_rm        = r_rm;
  assign resp.resp_valid     = (r_state == ST_RESP) & ~flush;
  assign resp.resp_sqrt      = r_sqrt;
  assign resp.resp_data      = r_resp_data;
  assign resp.resp_flags     = r_resp_flags;
  assign resp.resp_tag       = r_tag;
  assign resp.resp_latency   = r_resp_lat;
  assign busy                = (r_state != ST_IDLE);
  assign protocol_err        = r_perr;

  assign w_accept   = (r_state == ST_IDLE) & req.req_valid;
  assign w_issue_hs = unit.unit_in_valid & unit.unit_in_ready;
  assign w_capture  = (r_state == ST_WAIT) & w_match & ~flush;

  always_comb begin
    w_state_nxt = r_state;
    w_perr_set  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_perr_set = w_any;
        if (req.req_valid) w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        w_perr_set = w_any;
        if (flush)                   w_state_nxt = ST_IDLE;
        else if (unit.unit_in_ready) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        w_perr_set = w_other;
        if (w_match & flush) w_state_nxt = ST_IDLE;
        else if (w_match)    w_state_nxt = ST_RESP;
        else if (flush)      w_state_nxt = ST_DRAIN;
      end
      ST_RESP: begin
        w_perr_set = w_any;
        if (flush | resp.resp_ready) w_state_nxt = ST_IDLE;
      end
      ST_DRAIN: begin
        w_perr_set = w_other;
        if (w_match) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_sqrt       <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_rm         <= '0;
      r_tag        <= '0;
      r_lat        <= '0;
      r_resp_data  <= '0;
      r_resp_flags <= '0;
      r_resp_lat   <= '0;
      r_perr       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_sqrt <= req.req_sqrt;
        r_a    <= req.req_a;
        r_b    <= req.req_b;
        r_rm   <= req.req_rm;
        r_tag  <= req.req_tag;
      end
      // Latency reported is the edge count from the issue handshake to the capturing edge.
      if (w_issue_hs)                 r_lat <= '0;
      else if (r_state == ST_WAIT)    r_lat <= w_lat_inc;
      if (w_capture) begin
        r_resp_data  <= unit.unit_out;
        r_resp_flags <= unit.unit_exc_flags;
        r_resp_lat   <= w_lat_inc;
      end
      if (w_perr_set) r_perr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_div_sqrt_issue_ctrl.sv
// Directed self-checking bench for div_sqrt_issue_ctrl; the bench drives the unit side by hand.
module tb_div_sqrt_issue_ctrl;
  import fpu_divsqrt_pkg::*;

  logic clock;
  logic reset;
  logic flush;
  logic busy;
  logic protocol_err;
  int   n_checks;
  int   n_pass;

  ds_req_if  #(.REC_W(65), .TAG_W(5)) rq();
  ds_unit_if #(.REC_W(65))            un();
  ds_resp_if #(.REC_W(65), .TAG_W(5)) rs();

  div_sqrt_issue_ctrl #(.EXP_W(11), .SIG_W(53), .REC_W(65), .TAG_W(5)) dut (
    .clock        (clock),
    .reset        (reset),
    .req          (rq.slave),
    .unit         (un.master),
    .resp         (rs.master),
    .flush        (flush),
    .busy         (busy),
    .protocol_err (protocol_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send(input logic s, input logic [64:0] a, input logic [64:0] b,
                      input logic [2:0] rm, input logic [4:0] tag);
    rq.req_valid = 1'b1;
    rq.req_sqrt  = s;
    rq.req_a     = a;
    rq.req_b     = b;
    rq.req_rm    = rm;
    rq.req_tag   = tag;
    check("req_ready_idle", rq.req_ready, 1);
    tick();
    rq.req_valid = 1'b0;
  endtask

  task automatic pulse(input logic is_sqrt, input logic [64:0] d, input logic [4:0] f);
    un.unit_out_valid_div  = ~is_sqrt;
    un.unit_out_valid_sqrt = is_sqrt;
    un.unit_out            = d;
    un.unit_exc_flags      = f;
    tick();
    un.unit_out_valid_div  = 1'b0;
    un.unit_out_valid_sqrt = 1'b0;
  endtask

  localparam logic [64:0] ONE  = 65'h0_8000_0000_0000_0000;
  localparam logic [64:0] TWO  = 65'h0_8010_0000_0000_0000;
  localparam logic [64:0] HALF = 65'h0_7FF0_0000_0000_0000;
  localparam logic [64:0] FOUR = 65'h0_8020_0000_0000_0000;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset = 1'b1;
    flush = 1'b0;
    rq.req_valid = 1'b0; rq.req_sqrt = 1'b0; rq.req_a = '0; rq.req_b = '0;
    rq.req_rm = '0; rq.req_tag = '0;
    un.unit_in_ready = 1'b0; un.unit_out_valid_div = 1'b0; un.unit_out_valid_sqrt = 1'b0;
    un.unit_out = '0; un.unit_exc_flags = '0;
    rs.resp_ready = 1'b0;
    #1;
    check("rst_req_ready", rq.req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_in_valid", un.unit_in_valid, 0);
    check("rst_resp_valid", rs.resp_valid, 0);
    check("rst_perr", protocol_err, 0);
    tick();
    reset = 1'b0;
    tick();

    // Divide 1.0/2.0, 20-cycle unit, consumer always ready
    un.unit_in_ready = 1'b1;
    rs.resp_ready = 1'b1;
    send(1'b0, ONE, TWO, RM_RNE, 5'd3);
    check("div_in_valid", un.unit_in_valid, 1);
    check("div_unit_a", un.unit_a, ONE);
    check("div_unit_b", un.unit_b, TWO);
    check("div_sqrt_op", un.unit_sqrt_op, 0);
    tick();
    un.unit_in_ready = 1'b0;
    check("div_wait_in_valid", un.unit_in_valid, 0);
    check("div_wait_busy", busy, 1);
    repeat (19) tick();
    pulse(1'b0, HALF, 5'd0);
    check("div_resp_valid", rs.resp_valid, 1);
    check("div_resp_data", rs.resp_data, HALF);
    check("div_resp_flags", rs.resp_flags, 0);
    check("div_resp_tag", rs.resp_tag, 3);
    check("div_resp_lat", rs.resp_latency, 20);
    check("div_resp_sqrt", rs.resp_sqrt, 0);
    check("div_resp_req_ready", rq.req_ready, 0);
    tick();
    check("div_done_resp_valid", rs.resp_valid, 0);
    check("div_done_req_ready", rq.req_ready, 1);

    // Sqrt with inReady low for 5 cycles, then 10 cycles of response backpressure
    rs.resp_ready = 1'b0;
    send(1'b1, FOUR, 65'h1_2345, RM_RUP, 5'd7);
    for (int i = 0; i < 5; i++) begin
      check("sq_hold_valid", un.unit_in_valid, 1);
      check("sq_hold_a", un.unit_a, FOUR);
      check("sq_hold_rm", un.unit_rm, RM_RUP);
      tick();
    end
    un.unit_in_ready = 1'b1;
    check("sq_hs_valid", un.unit_in_valid, 1);
    tick();
    un.unit_in_ready = 1'b0;
    check("sq_single_issue", un.unit_in_valid, 0);
    repeat (2) tick();
    pulse(1'b1, TWO, 5'b00001);
    rq.req_valid = 1'b1;
    rq.req_sqrt = 1'b0; rq.req_a = TWO; rq.req_b = ONE; rq.req_rm = RM_RTZ; rq.req_tag = 5'd9;
    for (int i = 0; i < 10; i++) begin
      check("bp_resp_valid", rs.resp_valid, 1);
      check("bp_resp_data", rs.resp_data, TWO);
      check("bp_req_ready", rq.req_ready, 0);
      tick();
    end
    check("sq_resp_sqrt", rs.resp_sqrt, 1);
    check("sq_resp_flags", rs.resp_flags, 5'b00001);
    check("sq_resp_tag", rs.resp_tag, 7);
    check("sq_resp_lat", rs.resp_latency, 3);
    rs.resp_ready = 1'b1;
    tick();
    check("bp_next_req_ready", rq.req_ready, 1);
    tick();
    rq.req_valid = 1'b0;
    check("bp_next_in_valid", un.unit_in_valid, 1);
    check("bp_next_unit_a", un.unit_a, TWO);

    // Flush 3 cycles after issue, then drain the late divide pulse
    un.unit_in_ready = 1'b1;
    tick();
    un.unit_in_ready = 1'b0;
    repeat (2) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_state_drain", dut.r_state, ST_DRAIN);
    check("fl_busy", busy, 1);
    repeat (4) begin
      check("fl_no_resp", rs.resp_valid, 0);
      tick();
    end
    pulse(1'b0, ONE, 5'b10000);
    check("fl_busy_after", busy, 0);
    check("fl_resp_after", rs.resp_valid, 0);
    check("fl_perr", protocol_err, 0);
    un.unit_in_ready = 1'b1;
    send(1'b0, FOUR, TWO, RM_RDN, 5'd12);
    tick();
    un.unit_in_ready = 1'b0;
    tick();
    pulse(1'b0, TWO, 5'b00000);
    check("fl_next_valid", rs.resp_valid, 1);
    check("fl_next_tag", rs.resp_tag, 12);
    check("fl_next_lat", rs.resp_latency, 2);
    tick();

    // Flush together with the matching pulse
    un.unit_in_ready = 1'b1;
    send(1'b1, ONE, '0, RM_RMM, 5'd1);
    tick();
    un.unit_in_ready = 1'b0;
    flush = 1'b1;
    pulse(1'b1, ONE, 5'd0);
    flush = 1'b0;
    check("fp_resp_valid", rs.resp_valid, 0);
    check("fp_busy", busy, 0);
    check("fp_perr", protocol_err, 0);

    // Wrong-type pulse in WAIT and a stray pulse in IDLE
    un.unit_in_ready = 1'b1;
    send(1'b0, TWO, FOUR, RM_RNE, 5'd20);
    tick();
    un.unit_in_ready = 1'b0;
    pulse(1'b1, FOUR, 5'b11111);
    check("pe_wrong_perr", protocol_err, 1);
    check("pe_wrong_busy", busy, 1);
    check("pe_wrong_resp", rs.resp_valid, 0);
    pulse(1'b0, HALF, 5'b00100);
    check("pe_div_valid", rs.resp_valid, 1);
    check("pe_div_data", rs.resp_data, HALF);
    check("pe_div_flags", rs.resp_flags, 5'b00100);
    check("pe_div_lat", rs.resp_latency, 2);
    tick();
    pulse(1'b0, ONE, 5'd0);
    check("pe_idle_busy", busy, 0);
    check("pe_idle_perr", protocol_err, 1);

    // Reset in the middle of WAIT
    un.unit_in_ready = 1'b1;
    send(1'b0, FOUR, FOUR, RM_RTZ, 5'd31);
    tick();
    un.unit_in_ready = 1'b0;
    tick();
    check("rm_busy_pre", busy, 1);
    check("rm_perr_pre", protocol_err, 1);
    reset = 1'b1;
    #1;
    check("rm_req_ready", rq.req_ready, 0);
    check("rm_busy", busy, 0);
    check("rm_perr", protocol_err, 0);
    check("rm_unit_a", un.unit_a, 0);
    check("rm_resp_data", rs.resp_data, 0);
    check("rm_resp_tag", rs.resp_tag, 0);
    check("rm_resp_lat", rs.resp_latency, 0);
    tick();
    reset = 1'b0;
    tick();
    check("rm_after_ready", rq.req_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
